// File: rtl/iter_alu.sv
// iter_alu: multi-cycle integer ALU covering the RV32I ALU ops and the RV32M
// multiply/divide set, behind a valid/ready handshake.
// Base ops finish in one registered cycle; M ops iterate one bit per cycle.
// Build option: define ITER_ALU_FAST_MUL_EN to give MUL/MULH/MULHSU/MULHU a
// single-cycle combinational multiplier (divide stays iterative).
module iter_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Iteration control
  logic [SHW-1:0] cnt;
  logic           last;

  // Operand preparation (combinational from the request)
  logic            a_sgn, b_sgn;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  // Iterative datapath state, captured at accept
  logic [2:0]        f3_q;
  logic              negq_q;
  logic              nega_q;
  logic              bz_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  // One iteration step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_try;
  logic              div_ge;
  logic [XLEN-1:0]   rem_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;

`ifdef ITER_ALU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Single-cycle base operations; shifts only look at the low SHW bits of y.
  function automatic logic [XLEN-1:0] base_alu(input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y,
                                               input logic [3:0]      sel);
    logic signed [XLEN-1:0] xs;
    logic signed [XLEN-1:0] ys;
    logic [SHW-1:0]         sh;
    xs = $signed(x);
    ys = $signed(y);
    sh = y[SHW-1:0];
    case (sel)
      4'b0000: base_alu = x & y;
      4'b0001: base_alu = x | y;
      4'b0010: base_alu = x + y;
      4'b0100: base_alu = x ^ y;
      4'b0101: base_alu = x << sh;
      4'b0110: base_alu = x - y;
      4'b0111: base_alu = x >> sh;
      4'b1000: base_alu = {{(XLEN-1){1'b0}}, (xs < ys)};
      4'b1101: base_alu = $unsigned(xs >>> sh);
      default: base_alu = '0;
    endcase
  endfunction

  // Restore the product sign and pick the low or high half.
  function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] p,
                                              input logic              neg,
                                              input logic              lo);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    mul_fix = lo ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  // Restore quotient/remainder signs; divide-by-zero yields all ones for the
  // quotient, and the remainder path already carries the dividend through.
  function automatic logic [XLEN-1:0] div_fix(input logic [XLEN-1:0] q,
                                              input logic [XLEN-1:0] r,
                                              input logic            negq,
                                              input logic            negr,
                                              input logic            bz,
                                              input logic            is_rem);
    if (is_rem)
      div_fix = negr ? -r : r;
    else if (bz)
      div_fix = '1;
    else
      div_fix = negq ? -q : q;
  endfunction

  // Signedness per funct3 and operand magnitudes
  always_comb begin
    a_sgn = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
            (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    b_sgn = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
    neg_a = a_sgn & a[XLEN-1];
    neg_b = b_sgn & b[XLEN-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
  end

`ifdef ITER_ALU_FAST_MUL_EN
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    rem_try  = acc[2*XLEN-1:XLEN-1];
    div_ge   = (rem_try >= {1'b0, opnd});
    rem_diff = rem_try[XLEN-1:0] - opnd;
    div_nxt  = div_ge ? {rem_diff, acc[XLEN-2:0], 1'b1}
                      : {rem_try[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    acc_nxt  = f3_q[2] ? div_nxt : mul_nxt;
  end

  assign last = (state == BUSY) && (cnt == SHW'(XLEN-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!op[4])
            state_nxt = DONE;
`ifdef ITER_ALU_FAST_MUL_EN
          else if (!op[2])
            state_nxt = DONE;
`endif
          else
            state_nxt = BUSY;
        end
      end
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Iteration counter: cleared while idle, counts every BUSY cycle
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state == IDLE)
      cnt <= '0;
    else if (state == BUSY)
      cnt <= cnt + SHW'(1);
  end

  // ---- stage: accept -> iterate (operand capture, accumulator steps) ----
  // Multiply keeps the multiplier in acc low half; divide keeps the dividend.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      f3_q   <= op[2:0];
      negq_q <= neg_a ^ neg_b;
      nega_q <= neg_a;
      bz_q   <= (b == '0);
      opnd   <= op[2] ? mag_b : mag_a;
      acc    <= op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
    end else if (state == BUSY) begin
      acc <= acc_nxt;
    end
  end

  // ---- stage: result register (base op at accept, M op on last step) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (state == IDLE && in_valid) begin
      if (!op[4])
        result <= base_alu(a, b, op[3:0]);
`ifdef ITER_ALU_FAST_MUL_EN
      else if (!op[2])
        result <= mul_fix(fast_prod, neg_a ^ neg_b, op[1:0] == 2'b00);
`endif
    end else if (last) begin
      if (f3_q[2])
        result <= div_fix(acc_nxt[XLEN-1:0], acc_nxt[2*XLEN-1:XLEN],
                          negq_q, nega_q, bz_q, f3_q[1]);
      else
        result <= mul_fix(acc_nxt, negq_q, f3_q[1:0] == 2'b00);
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: table-driven and randomized bench for iter_alu, with a
// plain-arithmetic reference model; covers XLEN=32 and XLEN=8 instances.
module tb_iter_alu;

`ifdef ITER_ALU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int MUL_LAT = FAST ? 1 : 33;
  localparam int DIV_LAT = 33;

  localparam logic [4:0] OP_ADD = 5'b00010, OP_SUB = 5'b00110, OP_SLL = 5'b00101;
  localparam logic [4:0] OP_SRA = 5'b01101, OP_SLT = 5'b01000;
  localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM = 5'b10110, OP_REMU = 5'b10111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, zero;
  logic [31:0] a = '0, b = '0, result;
  logic [4:0]  op = '0;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, zero8;
  logic [7:0] a8 = '0, b8 = '0, result8;
  logic [4:0] op8 = '0;

  int checks = 0;
  int errors = 0;

  iter_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  iter_alu #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] res;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input longint unsigned x, input int w);
    longint t;
    t = longint'(x << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Reference model from the ISA rules, using 64-bit host arithmetic.
  function automatic longint unsigned ref_alu(input int w, input longint unsigned x,
                                              input longint unsigned y, input logic [4:0] o);
    longint unsigned m, r;
    longint xs, ys, minv, p;
    int sh;
    m    = (64'd1 << w) - 1;
    xs   = sx(x, w);
    ys   = sx(y, w);
    sh   = int'(y & longint'(w - 1));
    minv = -(longint'(1) << (w - 1));
    r    = 0;
    if (!o[4]) begin
      case (o[3:0])
        4'd0:  r = x & y;
        4'd1:  r = x | y;
        4'd2:  r = x + y;
        4'd4:  r = x ^ y;
        4'd5:  r = x << sh;
        4'd6:  r = x - y;
        4'd7:  r = x >> sh;
        4'd8:  r = (xs < ys) ? 1 : 0;
        4'd13: begin p = xs >>> sh; r = p; end
        default: r = 0;
      endcase
    end else begin
      case (o[2:0])
        3'd0: r = x * y;
        3'd1: begin p = xs * ys; p = p >>> w; r = p; end
        3'd2: begin p = xs * longint'(y); p = p >>> w; r = p; end
        3'd3: r = (x * y) >> w;
        3'd4: begin
          if (y == 0) r = m;
          else if (xs == minv && ys == -1) r = x;
          else begin p = xs / ys; r = p; end
        end
        3'd5: begin
          if (y == 0) r = m;
          else r = x / y;
        end
        3'd6: begin
          if (y == 0) r = x;
          else if (xs == minv && ys == -1) r = 0;
          else begin p = xs % ys; r = p; end
        end
        default: begin
          if (y == 0) r = x;
          else r = x % y;
        end
      endcase
    end
    return r & m;
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input int w);
    if (!o[4]) return 1;
    if (FAST && !o[2]) return 1;
    return w + 1;
  endfunction

  function automatic longint unsigned rnd_opnd(input int w);
    longint unsigned m;
    m = (64'd1 << w) - 1;
    case ($urandom_range(0, 5))
      0: return 0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Issue one request, measure accept-to-out_valid latency, check, drain.
  task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic [4:0] top,
                       input logic [31:0] er, input int elat, input string nm);
    int k;
    in_valid = 1'b1; a = ta; b = tb; op = top;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " latency"}, k + 1, elat);
    chk({nm, " result"}, result, er);
    chk({nm, " zero"}, zero, er == 0);
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic [4:0] top,
                      input logic [7:0] er, input int elat, input string nm);
    int k;
    in_valid8 = 1'b1; a8 = ta; b8 = tb; op8 = top;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    k = 0;
    while (!out_valid8 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " latency"}, k + 1, elat);
    chk({nm, " result"}, result8, er);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] ops [19];
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01101, 5'b00011, 5'b01010,
            5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, OP_ADD,    32'h80000000, 1,       "add_wrap"});
    vecs.push_back('{32'h00000005, 32'h00000005, OP_SUB,    32'h00000000, 1,       "sub_zero"});
    vecs.push_back('{32'h80000000, 32'h00000021, OP_SRA,    32'hC0000000, 1,       "sra_b21"});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, OP_SLT,    32'h00000001, 1,       "slt_neg"});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL,    32'h00000001, MUL_LAT, "mul"});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULHU,  32'hFFFFFFFE, MUL_LAT, "mulhu"});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULH,   32'h00000000, MUL_LAT, "mulh"});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000002, OP_MULHSU, 32'hFFFFFFFF, MUL_LAT, "mulhsu"});
    vecs.push_back('{32'hFFFFFFF9, 32'h00000002, OP_DIV,    32'hFFFFFFFD, DIV_LAT, "div_neg"});
    vecs.push_back('{32'hFFFFFFF9, 32'h00000002, OP_REM,    32'hFFFFFFFF, DIV_LAT, "rem_neg"});
    vecs.push_back('{32'd100,      32'h00000000, OP_DIVU,   32'hFFFFFFFF, DIV_LAT, "divu_by0"});
    vecs.push_back('{32'd100,      32'h00000000, OP_REMU,   32'd100,      DIV_LAT, "remu_by0"});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, OP_DIV,    32'h80000000, DIV_LAT, "div_ovf"});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, OP_REM,    32'h00000000, DIV_LAT, "rem_ovf"});
    vecs.push_back('{32'hFFFFFFF9, 32'h00000000, OP_DIV,    32'hFFFFFFFF, DIV_LAT, "div_by0"});
    vecs.push_back('{32'hFFFFFFF9, 32'h00000000, OP_REM,    32'hFFFFFFF9, DIV_LAT, "rem_by0"});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset zero", zero, 1);
    chk("reset8 in_ready", in_ready8, 1);

    foreach (vecs[i])
      run32(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].lat, vecs[i].nm);

    // Backpressure: result held in DONE, new requests ignored
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd10; b = 32'd20; op = OP_ADD;
    @(posedge clk); #1;
    a = 32'd1; b = 32'd1; op = OP_SUB;
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp result", result, 30);
      chk("bp in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", in_ready, 1);
    chk("bp release out_valid", out_valid, 0);
    chk("bp release result", result, 30);

    // Reset during a divide aborts it
    in_valid = 1'b1; a = 32'd1000; b = 32'd7; op = OP_DIVU;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort busy in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort result", result, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort stays idle", out_valid, 0);
    run32(32'd2, 32'd3, OP_ADD, 32'd5, 1, "add_after_abort");

    // Narrow instance
    run8(8'hFF, 8'hFF, OP_MULHU, 8'hFE, FAST ? 1 : 9, "x8_mulhu");
    run8(8'h01, 8'h0F, OP_SLL, 8'h80, 1, "x8_sll");

    for (int i = 0; i < 150; i++) begin
      logic [4:0]  o;
      logic [31:0] x, y, e;
      o = ops[$urandom_range(0, 18)];
      x = 32'(rnd_opnd(32));
      y = 32'(rnd_opnd(32));
      e = 32'(ref_alu(32, x, y, o));
      run32(x, y, o, e, exp_lat(o, 32), $sformatf("rand32 op=%0h a=%0h b=%0h", o, x, y));
    end

    for (int i = 0; i < 80; i++) begin
      logic [4:0] o;
      logic [7:0] x, y, e;
      o = ops[$urandom_range(0, 18)];
      x = 8'(rnd_opnd(8));
      y = 8'(rnd_opnd(8));
      e = 8'(ref_alu(8, x, y, o));
      run8(x, y, o, e, exp_lat(o, 8), $sformatf("rand8 op=%0h a=%0h b=%0h", o, x, y));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised multi-cycle successor to the core's single-cycle integer ALU.
- Executes the base RV32I ALU op set plus the RV32M multiply/divide set.
  - Base ops: one registered cycle.
  - M ops: iterative, one bit per cycle.
- Sits in EX behind a valid/ready handshake so the pipeline stalls on long ops; operand width is generic.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts request this cycle.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2/imm).
- op  in  5  operation select.
  - op[4]=0: base op, op[3:0] encoded AND 0000, OR 0001, ADD 0010, XOR 0100, SLL 0101, SUB 0110, SRL 0111, SLT 1000, SRA 1101.
  - op[4]=1: M op, op[2:0] = funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0 (combinational from result register).

Behaviour:
- One clock, clk; reset rst is synchronous, active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, iteration counter=0; any in-flight op is discarded.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a, b, op.
    - Base op: compute, load result, go DONE.
    - M op: go BUSY.
  - BUSY: in_ready=0. Counter runs XLEN cycles.
    - Multiply: shift-add on |a|, |b| magnitudes per signedness; 2*XLEN-bit product register.
    - Divide: restoring; XLEN-bit quotient and remainder.
    - When the counter reaches XLEN-1, apply sign fix-up, load result, go DONE.
  - DONE: out_valid=1, result held stable.
    - On out_ready, go IDLE next cycle (one bubble cycle; no accept in DONE).
- Latency, counted from accept edge T:
  - Base op: out_valid at T+1.
  - M op: out_valid at T+XLEN+1.
- Base ops:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT signed compare.
  - Shifts use b[SHW-1:0] only; SRA is arithmetic.
  - Any unlisted op[3:0] with op[4]=0 -> result 0.
- M results:
  - MUL: low XLEN bits.
  - MULH: high XLEN bits, signed x signed.
  - MULHSU: high XLEN bits, signed a x unsigned b.
  - MULHU: high XLEN bits, unsigned x unsigned.
- Divide corner cases, fixed by RISC-V spec:
  - b=0: DIV/DIVU quotient = all ones; REM/REMU = a.
  - a = -2^(XLEN-1), b = -1 (signed): DIV = a, REM = 0.
  - Both corner cases still take the full XLEN+1 latency (uniform timing).
- REM sign follows dividend; DIV rounds toward zero.
- Signals ignored while busy: in_valid/a/b/op are ignored outside IDLE; operands are captured only at accept.
- out_ready is ignored outside DONE. In DONE with out_ready low, result/out_valid hold indefinitely.
- rst asserted in BUSY or DONE aborts: next cycle IDLE, out_valid=0.

Optional Feature:
- Macro: ITER_ALU_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN-bit multiplier.
  - Path IDLE -> DONE directly; out_valid at T+1.
  - Divide remains iterative.
- Undefined:
  - All M ops iterative as above.
  - No hardware multiplier inferred.

Test Plan:
- Reset then base ops, XLEN=32, out_ready=1:
  - ADD a=0x7FFFFFFF, b=1 -> result 0x80000000 at T+1.
  - SUB a=5, b=5 -> result 0, zero=1.
  - SRA a=0x80000000, b=0x21 -> 0xC0000000 (shift 1).
  - SLT a=-1, b=1 -> 1.
- Multiply:
  - MUL 0xFFFFFFFF x 0xFFFFFFFF -> 1.
  - MULHU same operands -> 0xFFFFFFFE.
  - MULH same operands -> 0.
  - MULHSU a=-1, b=2 -> 0xFFFFFFFF.
  - Each: out_valid exactly at T+33 (T+1 with ITER_ALU_FAST_MUL_EN).
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - All at T+33.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored.
  - Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-op:
  - Start DIVU, assert rst at cycle 10 of BUSY -> next cycle out_valid=0, in_ready=1.
  - A following ADD 2+3 -> 5 at T+1.
- Parameter sweep, XLEN=8:
  - MULHU 0xFF x 0xFF -> 0xFE at T+9.
  - SLL a=1, b=0x0F -> 0x80 (shift uses b[2:0]=7).
